// File: rtl/mac_tile_mc.sv
// Systolic MAC tile: holds nch signed weights and folds nch input channels into one south partial sum.
// Optional build macro MAC_TILE_SAT_EN: saturate each accumulate step to the signed psum range instead of wrapping.
module mac_tile_mc #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int nch     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      in_w,
    input  logic [1:0]         inst_w,
    input  logic [psum_bw-1:0] in_n,
    output logic [bw-1:0]      out_e,
    output logic [1:0]         inst_e,
    output logic [psum_bw-1:0] out_s,
    output logic               out_s_valid,
    output logic               load_done
);
    localparam int CW = $clog2(nch + 1);
    localparam logic [CW-1:0] NCH_C  = CW'(nch);
    localparam logic [CW-1:0] LAST_C = CW'(nch - 1);

    logic [bw-1:0]      a_q, a_d;
    logic [1:0]         inst_e_q, inst_e_d;
    logic [bw-1:0]      w_q [nch];
    logic [bw-1:0]      w_d [nch];
    logic [CW-1:0]      load_cnt_q, load_cnt_d;
    logic [CW-1:0]      ch_cnt_q, ch_cnt_d;
    logic signed [psum_bw-1:0] acc_q, acc_d;
    logic [psum_bw-1:0] out_s_q, out_s_d;
    logic               valid_q, valid_d;
    logic               load_done_q, load_done_d;

    logic               ld, ex;
    logic [bw-1:0]      w_sel;
    logic signed [psum_bw-1:0] act_ext, wgt_ext, prod, base, sum;
`ifdef MAC_TILE_SAT_EN
    localparam logic signed [psum_bw-1:0] PMAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw-1:0] PMIN = {1'b1, {(psum_bw-1){1'b0}}};
    logic signed [psum_bw:0] sum_wide;
`endif

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        // Load wins over execute when both instruction bits are set.
        ld = inst_w[0];
        ex = inst_w[1] & ~inst_w[0];

        w_sel = '0;
        for (int i = 0; i < nch; i++) begin
            if (ch_cnt_q == CW'(i)) w_sel = w_q[i];
        end

        act_ext = signed'({{(psum_bw-bw){1'b0}}, in_w});
        wgt_ext = signed'({{(psum_bw-bw){w_sel[bw-1]}}, w_sel});
        prod    = act_ext * wgt_ext;
        base    = (ch_cnt_q == '0) ? signed'(in_n) : acc_q;
`ifdef MAC_TILE_SAT_EN
        sum_wide = {base[psum_bw-1], base} + {prod[psum_bw-1], prod};
        if (sum_wide[psum_bw] != sum_wide[psum_bw-1]) sum = sum_wide[psum_bw] ? PMIN : PMAX;
        else                                          sum = sum_wide[psum_bw-1:0];
`else
        sum = base + prod;
`endif

        a_d = a_q;
        if (inst_w != 2'b00) a_d = in_w;
        inst_e_d = {ex, ld && (load_cnt_q == NCH_C)};

        w_d        = w_q;
        load_cnt_d = load_cnt_q;
        if (ld && (load_cnt_q != NCH_C)) begin
            for (int i = 0; i < nch; i++) begin
                if (load_cnt_q == CW'(i)) w_d[i] = in_w;
            end
            load_cnt_d = load_cnt_q + CW'(1);
        end
        load_done_d = (load_cnt_d == NCH_C);

        ch_cnt_d = ch_cnt_q;
        acc_d    = acc_q;
        out_s_d  = '0;
        valid_d  = 1'b0;
        if (ex) begin
            acc_d = sum;
            if (ch_cnt_q == LAST_C) begin
                ch_cnt_d = '0;
                out_s_d  = sum;
                valid_d  = 1'b1;
            end else begin
                ch_cnt_d = ch_cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            inst_e_q    <= '0;
            load_cnt_q  <= '0;
            ch_cnt_q    <= '0;
            acc_q       <= '0;
            out_s_q     <= '0;
            valid_q     <= 1'b0;
            load_done_q <= 1'b0;
            // NOTE: the weight array is only nch flops and must read 0 before loading, so it is reset too.
            for (int i = 0; i < nch; i++) w_q[i] <= '0;
        end else begin
            a_q         <= a_d;
            inst_e_q    <= inst_e_d;
            load_cnt_q  <= load_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            acc_q       <= acc_d;
            out_s_q     <= out_s_d;
            valid_q     <= valid_d;
            load_done_q <= load_done_d;
            for (int i = 0; i < nch; i++) w_q[i] <= w_d[i];
        end
    end

    assign out_e       = a_q;
    assign inst_e      = inst_e_q;
    assign out_s       = out_s_q;
    assign out_s_valid = valid_q;
    assign load_done   = load_done_q;
endmodule

// File: tb/tb_mac_tile_mc.sv
// Scoreboard bench for mac_tile_mc (bw=4, psum_bw=16, nch=2): stimulus queues expected south sums, a monitor pops them.
module tb_mac_tile_mc;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_w;
    logic [1:0]  inst_w;
    logic [15:0] in_n;
    logic [3:0]  out_e;
    logic [1:0]  inst_e;
    logic [15:0] out_s;
    logic        out_s_valid;
    logic        load_done;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    mac_tile_mc #(.bw(4), .psum_bw(16), .nch(2)) dut (
        .clk(clk), .reset(reset), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
        .out_e(out_e), .inst_e(inst_e), .out_s(out_s), .out_s_valid(out_s_valid),
        .load_done(load_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid strobe must match the oldest queued sum on its due cycle.
    always @(negedge clk) begin
        exp_t e;
        if (out_s_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {16'h0, out_s}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("out_s", {16'h0, out_s}, {16'h0, e.val});
                check("valid_cycle", cyc, e.due);
            end
        end else begin
            check("out_s_idle_zero", {16'h0, out_s}, 32'h0);
        end
    end

    task automatic expect_s(input logic [15:0] v);
        exp_t e;
        e.val = v;
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic step(input logic [1:0] inst, input logic [3:0] d, input logic [15:0] n);
        inst_w = inst;
        in_w   = d;
        in_n   = n;
        @(posedge clk);
        #1;
    endtask

    task automatic check_fwd(input string tag, input logic [3:0] e, input logic [1:0] ie, input logic ld);
        check({tag, "_out_e"}, {28'h0, out_e}, {28'h0, e});
        check({tag, "_inst_e"}, {30'h0, inst_e}, {30'h0, ie});
        check({tag, "_load_done"}, {31'h0, load_done}, {31'h0, ld});
    endtask

    task automatic check_all_zero(input string tag);
        check_fwd(tag, 4'h0, 2'b00, 1'b0);
        check({tag, "_out_s"}, {16'h0, out_s}, 32'h0);
        check({tag, "_valid"}, {31'h0, out_s_valid}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; inst_w = 2'b00; in_w = 4'h0; in_n = 16'h0;

        // 1. Reset held with toggling inputs, then idle after release.
        #2;
        check_all_zero("rst_t0");
        step(2'b01, 4'h9, 16'h1234); check_all_zero("rst_ld");
        step(2'b10, 4'hF, 16'hFFFF); check_all_zero("rst_ex");
        step(2'b11, 4'h6, 16'h0042); check_all_zero("rst_both");
        reset = 1'b1;
        repeat (3) step(2'b00, 4'h0, 16'h0);
        check_all_zero("idle");

        // 2. Load 3, E, 5: third word overflows east.
        step(2'b01, 4'h3, 16'h0); check_fwd("ld1", 4'h3, 2'b00, 1'b0);
        step(2'b01, 4'hE, 16'h0); check_fwd("ld2", 4'hE, 2'b00, 1'b1);
        step(2'b01, 4'h5, 16'h0); check_fwd("ld3", 4'h5, 2'b01, 1'b1);
        step(2'b00, 4'h0, 16'h0); check_fwd("ld_idle", 4'h5, 2'b00, 1'b1);

        // 3. 100 + 4*3 + 7*(-2) = 98.
        step(2'b10, 4'h4, 16'd100); check_fwd("ex1", 4'h4, 2'b10, 1'b1);
        expect_s(16'd98);
        step(2'b10, 4'h7, 16'd100); check_fwd("ex2", 4'h7, 2'b10, 1'b1);
        repeat (2) step(2'b00, 4'h0, 16'h0);

        // 4. Gap mid-group; in_n ignored off channel 0.
        step(2'b10, 4'h4, 16'd100);
        step(2'b00, 4'h0, 16'd500);
        expect_s(16'd98);
        step(2'b10, 4'h7, 16'd500);
        repeat (2) step(2'b00, 4'h0, 16'h0);

        // 5. Overflow: 0x7FF0 + 105 + 105.
        reset = 1'b0;
        #1 check_all_zero("rst5");
        @(posedge clk); #1;
        reset = 1'b1;
        step(2'b01, 4'h7, 16'h0);
        step(2'b01, 4'h7, 16'h0); check_fwd("ld77", 4'h7, 2'b00, 1'b1);
        step(2'b10, 4'hF, 16'h7FF0);
`ifdef MAC_TILE_SAT_EN
        expect_s(16'h7FFF);
`else
        expect_s(16'h80C2);
`endif
        step(2'b10, 4'hF, 16'h7FF0);
        repeat (2) step(2'b00, 4'h0, 16'h0);

        // 6. Reset between activations discards the group; inst 11 acts as load only.
        step(2'b10, 4'h4, 16'd100);
        reset = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk); #1;
        check_all_zero("rst_mid_hold");
        reset = 1'b1;
        step(2'b11, 4'h3, 16'd100); check_fwd("ld11", 4'h3, 2'b00, 1'b0);
        step(2'b01, 4'hE, 16'd100); check_fwd("ldE", 4'hE, 2'b00, 1'b1);
        step(2'b10, 4'h4, 16'd100);
        step(2'b11, 4'h9, 16'd777); check_fwd("ld11_full", 4'h9, 2'b01, 1'b1);
        expect_s(16'd98);
        step(2'b10, 4'h7, 16'd777);
        repeat (3) step(2'b00, 4'h0, 16'h0);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
